// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC and instruction register and runs a
// req/ack read handshake with instruction memory on behalf of the control unit.
module instr_fetch #(
  parameter int ADDR_W = 6,
  parameter int INSTR_W = 20,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               fetch_req,
  input  logic               pc_update,
  input  logic [1:0]         pc_sel,
  input  logic [ADDR_W-1:0]  jump_addr,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instruction,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  output logic [ADDR_W-1:0]  pc,
  output logic               busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  localparam logic [1:0] SEL_HOLD  = 2'b00;
  localparam logic [1:0] SEL_INC   = 2'b01;
  localparam logic [1:0] SEL_JUMP  = 2'b10;
  localparam logic [1:0] SEL_RESET = 2'b11;

  state_t             state_reg;
  logic               flush_reg;
  logic [ADDR_W-1:0]  pc_reg;
  logic [ADDR_W-1:0]  pc_next;
  logic               imem_req_reg;
  logic [ADDR_W-1:0]  imem_addr_reg;
  logic [INSTR_W-1:0] instruction_reg;
  logic [ADDR_W-1:0]  instr_pc_reg;
  logic               instr_valid_reg;
  logic               flush_now;
  logic               flush_pending;

  always_comb begin
    pc_next = pc_reg;
    if (pc_update) begin
      case (pc_sel)
        SEL_HOLD:  pc_next = pc_reg;
        SEL_INC:   pc_next = pc_reg + ADDR_W'(1);
        SEL_JUMP:  pc_next = jump_addr;
        SEL_RESET: pc_next = RESET_PC;
        default:   pc_next = pc_reg;
      endcase
    end
  end

  // Only discontinuous PC changes invalidate the outstanding fetch; PC+1 does not.
  assign flush_now     = pc_update && (pc_sel == SEL_JUMP || pc_sel == SEL_RESET);
  assign flush_pending = flush_reg || flush_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_IDLE;
      flush_reg       <= 1'b0;
      pc_reg          <= RESET_PC;
      imem_req_reg    <= 1'b0;
      imem_addr_reg   <= '0;
      instruction_reg <= '0;
      instr_pc_reg    <= '0;
      instr_valid_reg <= 1'b0;
    end else begin
      pc_reg          <= pc_next;
      instr_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (fetch_req) begin
            imem_addr_reg <= pc_next;
            imem_req_reg  <= 1'b1;
            state_reg     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (imem_ack) begin
            if (flush_pending) begin
              // Stale data: drop it and re-issue from the new PC without leaving WAIT.
              flush_reg     <= 1'b0;
              imem_addr_reg <= pc_next;
            end else begin
              instruction_reg <= imem_rdata;
              instr_pc_reg    <= imem_addr_reg;
              instr_valid_reg <= 1'b1;
              imem_req_reg    <= 1'b0;
              state_reg       <= ST_IDLE;
            end
          end else if (flush_now) begin
            flush_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          imem_req_reg <= 1'b0;
          flush_reg    <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = imem_req_reg;
  assign imem_addr   = imem_addr_reg;
  assign instruction = instruction_reg;
  assign instr_pc    = instr_pc_reg;
  assign instr_valid = instr_valid_reg;
  assign pc          = pc_reg;
  assign busy        = (state_reg == ST_WAIT);

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fetch_req, pc_update, imem_ack;
  logic [1:0]  pc_sel;
  logic [5:0]  jump_addr;
  logic        imem_req;
  logic [5:0]  imem_addr;
  logic [19:0] imem_rdata;
  logic [19:0] instruction;
  logic [5:0]  instr_pc;
  logic        instr_valid;
  logic [5:0]  pc;
  logic        busy;

  int vectors = 0;
  int miscompares = 0;

  // Model: architectural PC, one optional outstanding fetch, a "stale" mark on it.
  logic [5:0]  m_pc, m_addr, m_ipc;
  logic        m_out, m_stale, m_valid;
  logic [19:0] m_instr;

  instr_fetch dut (
    .clk(clk), .rst_n(rst_n), .fetch_req(fetch_req), .pc_update(pc_update),
    .pc_sel(pc_sel), .jump_addr(jump_addr), .imem_req(imem_req),
    .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .instruction(instruction), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .pc(pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pc = 6'd0; m_addr = 6'd0; m_ipc = 6'd0; m_instr = 20'd0;
    m_out = 1'b0; m_stale = 1'b0; m_valid = 1'b0;
  endtask

  task automatic compare_all();
    chk("pc", pc, m_pc);
    chk("busy", busy, m_out);
    chk("imem_req", imem_req, m_out);
    chk("imem_addr", imem_addr, m_addr);
    chk("instruction", instruction, m_instr);
    chk("instr_pc", instr_pc, m_ipc);
    chk("instr_valid", instr_valid, m_valid);
  endtask

  // Called at a falling edge: drive, predict, clock, compare at the next falling edge.
  task automatic step(input logic fr, input logic pu, input logic [1:0] sel,
                      input logic [5:0] ja, input logic ack, input logic [19:0] rd);
    logic [5:0] target;
    logic       jumpy;
    fetch_req = fr; pc_update = pu; pc_sel = sel; jump_addr = ja;
    imem_ack = ack; imem_rdata = rd;
    case ({pu, sel})
      3'b101:  target = m_pc + 6'd1;
      3'b110:  target = ja;
      3'b111:  target = 6'd0;
      default: target = m_pc;
    endcase
    jumpy = pu && sel[1];
    @(posedge clk);
    m_valid = 1'b0;
    if (!m_out) begin
      if (fr) begin m_out = 1'b1; m_addr = target; end
    end else if (ack) begin
      if (m_stale || jumpy) begin
        m_stale = 1'b0; m_addr = target;
      end else begin
        m_instr = rd; m_ipc = m_addr; m_valid = 1'b1; m_out = 1'b0;
      end
    end else if (jumpy) begin
      m_stale = 1'b1;
    end
    m_pc = target;
    @(negedge clk);
    compare_all();
    $display("step fr=%0b pu=%0b sel=%0d ja=%0d ack=%0b rd=%05h -> pc=%0d req=%0b addr=%0d valid=%0b instr=%05h ipc=%0d",
             fr, pu, sel, ja, ack, rd, pc, imem_req, imem_addr, instr_valid, instruction, instr_pc);
  endtask

  task automatic idle(); step(0, 0, 2'b00, 6'd0, 0, 20'd0); endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
    compare_all();
  endtask

  int valids;

  initial begin
    rst_n = 1'b0; fetch_req = 0; pc_update = 0; pc_sel = 0; jump_addr = 0;
    imem_ack = 0; imem_rdata = 20'hABCDE;
    model_reset();
    @(negedge clk);
    chk("rst_pc", pc, 0);
    chk("rst_instr", instruction, 0);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    compare_all();
    rst_n = 1'b1;

    // Fetch with PC+1 in the same cycle, ack in first WAIT cycle.
    step(0, 1, 2'b10, 6'd5, 0, 20'd0);
    chk("t2_pc5", pc, 5);
    step(1, 1, 2'b01, 6'd0, 0, 20'd0);
    chk("t2_addr", imem_addr, 6);
    chk("t2_req", imem_req, 1);
    chk("t2_novalid", instr_valid, 0);
    step(0, 0, 2'b00, 6'd0, 1, 20'h51200);
    chk("t2_valid", instr_valid, 1);
    chk("t2_instr", instruction, 20'h51200);
    chk("t2_ipc", instr_pc, 6);
    idle();
    chk("t2_valid_once", instr_valid, 0);
    chk("t2_req_low", imem_req, 0);

    // PC wrap 63 -> 0.
    step(0, 1, 2'b10, 6'd63, 0, 20'd0);
    step(0, 1, 2'b01, 6'd0, 0, 20'd0);
    chk("t3_pc_wrap", pc, 0);
    step(1, 0, 2'b00, 6'd0, 0, 20'd0);
    chk("t3_addr", imem_addr, 0);
    step(0, 0, 2'b00, 6'd0, 1, 20'h12345);
    idle();

    // Jump during WAIT flushes the outstanding fetch.
    step(0, 1, 2'b10, 6'd3, 0, 20'd0);
    step(1, 0, 2'b00, 6'd0, 0, 20'd0);
    chk("t4_addr3", imem_addr, 3);
    idle();
    step(0, 1, 2'b10, 6'd40, 0, 20'd0);
    idle();
    step(0, 0, 2'b00, 6'd0, 1, 20'hDEAD0);
    chk("t4_drop_valid", instr_valid, 0);
    chk("t4_drop_instr", instruction, 20'h12345);
    chk("t4_req_high", imem_req, 1);
    chk("t4_addr40", imem_addr, 40);
    step(0, 0, 2'b00, 6'd0, 1, 20'h4BEEF);
    chk("t4_valid", instr_valid, 1);
    chk("t4_instr", instruction, 20'h4BEEF);
    chk("t4_ipc", instr_pc, 40);

    // fetch_req and PC+1 during WAIT leave the fetch alone.
    valids = 0;
    step(1, 0, 2'b00, 6'd0, 0, 20'd0);
    if (instr_valid) valids++;
    step(1, 1, 2'b01, 6'd0, 0, 20'd0);
    if (instr_valid) valids++;
    chk("t5_addr_held", imem_addr, 40);
    chk("t5_pc_inc", pc, 41);
    step(1, 0, 2'b00, 6'd0, 1, 20'h0A0A0);
    if (instr_valid) valids++;
    chk("t5_ipc", instr_pc, 40);
    idle();
    if (instr_valid) valids++;
    idle();
    if (instr_valid) valids++;
    chk("t5_one_valid", valids, 1);
    chk("t5_no_req", imem_req, 0);

    // Reset in WAIT, then a late ack.
    pulse_reset();
    step(1, 0, 2'b00, 6'd0, 0, 20'd0);
    pulse_reset();
    step(0, 0, 2'b00, 6'd0, 1, 20'h77777);
    chk("t6_req", imem_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_instr", instruction, 0);
    chk("t6_valid", instr_valid, 0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) pulse_reset();
      step($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
           2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)),
           $urandom_range(0, 2) == 0, 20'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Upstream neighbour of the control unit. Owns the program counter and the instruction register. Runs a req/ack read handshake with instruction memory and presents each 20-bit instruction to the control unit with a one-cycle valid strobe.
- PC sourcing uses the control unit's M3 encoding and its 6-bit jump target (alpha).
- Jumps issued while a fetch is outstanding flush that fetch and re-fetch from the new PC automatically.

Parameters:
ADDR_W, 6, PC and instruction-memory address width (matches the 6-bit jump target)
INSTR_W, 20, instruction width (opcode in bits [19:16])
RESET_PC, 0, PC value after reset and for pc_sel=11

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
fetch_req  input  1  control unit requests the next instruction (one-cycle strobe)
pc_update  input  1  strobe: apply pc_sel to PC this cycle
pc_sel  input  2  PC source: 00 hold, 01 PC+1, 10 load jump_addr, 11 load RESET_PC
jump_addr  input  ADDR_W  jump target (alpha)
imem_req  output  1  instruction memory read request
imem_addr  output  ADDR_W  read address, stable while imem_req=1
imem_ack  input  1  memory returns imem_rdata this cycle
imem_rdata  input  INSTR_W  read data
instruction  output  INSTR_W  instruction register, to the control unit
instr_pc  output  ADDR_W  address of the instruction currently held in the instruction register
instr_valid  output  1  one-cycle pulse when the instruction register is updated
pc  output  ADDR_W  current PC
busy  output  1  high while in state WAIT

Behaviour:
- Reset (async, rst_n=0):
  - pc=RESET_PC; instruction=0; instr_pc=0; instr_valid=0; imem_req=0; imem_addr=0; flush=0; state=IDLE.
  - Asserting reset in WAIT aborts the fetch. A late imem_ack after reset is ignored because IDLE ignores ack.
- pc_next (combinational):
  - pc_update=0 or pc_sel=00: pc.
  - 01: pc+1, modulo 2^ADDR_W (63 wraps to 0).
  - 10: jump_addr.
  - 11: RESET_PC.
  - pc <= pc_next every cycle, in any state.
- State IDLE:
  - On fetch_req: imem_addr <= pc_next, imem_req <= 1, go to WAIT.
  - A same-cycle pc_update therefore takes effect before the fetch.
  - imem_ack is ignored.
- State WAIT:
  - imem_req and imem_addr are held stable.
  - fetch_req is ignored.
  - pc_update with pc_sel=10 or 11 sets flush.
  - pc_update with pc_sel=01 updates pc only. The outstanding fetch is unaffected and no flush occurs.
- WAIT, imem_ack=1, no flush pending (flush=0 and no flushing update this cycle):
  - instruction <= imem_rdata; instr_pc <= imem_addr; instr_valid <= 1 for the next cycle only.
  - imem_req <= 0; go to IDLE.
- WAIT, imem_ack=1, flush pending (flush=1 or a flushing update this cycle):
  - Data is discarded and instruction is unchanged; no instr_valid.
  - flush <= 0; imem_addr <= pc_next; imem_req stays 1; remain in WAIT. This is the automatic re-fetch.
- Handshake latency:
  - imem_req rises the cycle after fetch_req.
  - Minimum fetch_req-to-instr_valid latency is 2 cycles (ack in the first WAIT cycle).
  - imem_req falls the cycle after the accepted ack, so it is never high in IDLE.
- Throughput: one instruction per fetch_req. There is no prefetch.

Test Plan:
- Reset with imem_rdata=20'hABCDE present -> pc=0, instruction=0, imem_req=0, instr_valid=0.
- pc=5, fetch_req+pc_update(01), imem_rdata=20'h5_1200 and ack one cycle after req -> imem_addr=6; instruction=20'h51200 and instr_pc=6 with a single instr_valid pulse 2 cycles after fetch_req; imem_req low afterwards.
- pc=63, pc_update(01) then fetch_req -> pc=0, imem_addr=0 (wrap).
- Fetch at addr 3 with ack delayed 4 cycles; pc_update(10, jump_addr=40) in cycle 2 of WAIT -> first ack's data dropped with no instr_valid; imem_req stays high with imem_addr=40; the second ack loads instruction and sets instr_pc=40.
- WAIT with fetch_req pulses and pc_update(01) during the wait -> no second request, imem_addr unchanged, pc advanced by 1, exactly one instr_valid.
- rst_n low in WAIT, then imem_ack after release -> state IDLE, imem_req=0, instruction stays 0, no instr_valid.
